// File: rtl/sig_control_timed_pkg.sv
// Shared lamp codes, state encodings and the lamp decode used by the
// highway/country signal controller.
package sig_control_timed_pkg;

  typedef enum logic [1:0] {
    LAMP_RED    = 2'd0,
    LAMP_YELLOW = 2'd1,
    LAMP_GREEN  = 2'd2,
    LAMP_OFF    = 2'd3
  } lamp_e;

  typedef enum logic [2:0] {
    S_HG  = 3'd0,
    S_HY  = 3'd1,
    S_AR1 = 3'd2,
    S_CG  = 3'd3,
    S_CY  = 3'd4,
    S_AR2 = 3'd5,
    S_FL  = 3'd6
  } state_e;

  localparam logic [2:0] S_ILLEGAL = 3'd7;

  typedef struct packed {
    lamp_e hwy;
    lamp_e cntry;
  } lamps_t;

  // Moore decode; anything not explicitly lit (AR states, illegal code) is RED/RED.
  function automatic lamps_t decode_lamps(input logic [2:0] st, input logic phase_on);
    lamps_t l;
    l.hwy   = LAMP_RED;
    l.cntry = LAMP_RED;
    case (st)
      S_HG: l.hwy   = LAMP_GREEN;
      S_HY: l.hwy   = LAMP_YELLOW;
      S_CG: l.cntry = LAMP_GREEN;
      S_CY: l.cntry = LAMP_YELLOW;
      S_FL: begin
        if (phase_on) begin
          l.hwy = LAMP_YELLOW;
        end else begin
          l.hwy   = LAMP_OFF;
          l.cntry = LAMP_OFF;
        end
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sig_control_timed_dwell_timer.sv
// Cycles-in-state counter: restarts to zero on request and saturates at
// all-ones so long dwells never wrap back into a low count.
module sig_dwell_timer #(
  parameter int TW = 8
) (
  input  logic          clock_i,
  input  logic          clear_i,
  input  logic          restart_i,
  output logic [TW-1:0] count_o
);

  logic [TW-1:0] count_q;
  logic [TW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (count_q != {TW{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sig_control_timed.sv
// Highway/country-road signal controller with dwell timing, clearance
// all-reds and a night flashing mode.
//
//  state | meaning
//  S_HG  | highway green, country red; holds for minimum green
//  S_HY  | highway yellow
//  S_AR1 | all red, clearing towards country green
//  S_CG  | country green while a car waits, up to max green
//  S_CY  | country yellow
//  S_AR2 | all red, clearing towards highway green (also flash exit)
//  S_FL  | night flashing: hwy yellow/off, cntry red/off
//  7     | illegal: red/red, recovers to S_HG
module sig_control_timed
  import sig_control_timed_pkg::*;
#(
  parameter int TW              = 8,
  parameter int Y2R_DELAY       = 3,
  parameter int R2G_DELAY       = 2,
  parameter int HWY_MIN_GREEN   = 8,
  parameter int CNTRY_MAX_GREEN = 16,
  parameter int FLASH_HALF      = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  input  logic       flash_mode,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic [2:0] state
);

  localparam logic [TW-1:0] Y2R_LAST   = TW'(Y2R_DELAY - 1);
  localparam logic [TW-1:0] R2G_LAST   = TW'(R2G_DELAY - 1);
  localparam logic [TW-1:0] HWY_LAST   = TW'(HWY_MIN_GREEN - 1);
  localparam logic [TW-1:0] CNTRY_LAST = TW'(CNTRY_MAX_GREEN - 1);
  localparam logic [TW-1:0] FLASH_LAST = TW'(FLASH_HALF - 1);

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic          phase_q;
  logic          phase_d;
  logic [TW-1:0] timer;
  logic          flash_toggle;
  logic          timer_restart;
  lamps_t        lamps;

  sig_dwell_timer #(
    .TW (TW)
  ) u_dwell_timer (
    .clock_i   (clock),
    .clear_i   (clear),
    .restart_i (timer_restart),
    .count_o   (timer)
  );

  always_comb begin
    state_d      = state_q;
    flash_toggle = 1'b0;
    case (state_q)
      S_HG: begin
        if (flash_mode) begin
          state_d = S_FL;
        end else if (X && (timer >= HWY_LAST)) begin
          state_d = S_HY;
        end
      end
      S_HY:  if (timer == Y2R_LAST) state_d = S_AR1;
      S_AR1: if (timer == R2G_LAST) state_d = S_CG;
      S_CG:  if (!X || (timer == CNTRY_LAST)) state_d = S_CY;
      S_CY:  if (timer == Y2R_LAST) state_d = S_AR2;
      S_AR2: if (timer == R2G_LAST) state_d = S_HG;
      S_FL: begin
        // Leaving flash takes priority over a half-period toggle.
        if (!flash_mode) begin
          state_d = S_AR2;
        end else if (timer == FLASH_LAST) begin
          flash_toggle = 1'b1;
        end
      end
      default: state_d = S_HG;
    endcase
  end

  assign timer_restart = (state_d != state_q) || flash_toggle;

  always_comb begin
    phase_d = phase_q;
    if ((state_q != S_FL) && (state_d == S_FL)) begin
      phase_d = 1'b1;
    end else if (flash_toggle) begin
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_HG;
      phase_q <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  assign lamps = decode_lamps(state_q, phase_q);
  assign hwy   = lamps.hwy;
  assign cntry = lamps.cntry;
  assign state = state_q;

endmodule

// File: tb/tb_sig_control_timed.sv
// Scoreboard bench for sig_control_timed: per-cycle expected state/lamps are
// queued from the timing rules, then popped and compared after each edge.
module tb_sig_control_timed;
  import sig_control_timed_pkg::*;

  logic       clock = 1'b0;
  logic       clear;
  logic       X;
  logic       flash_mode;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic [2:0] state;

  sig_control_timed dut (
    .clock      (clock),
    .clear      (clear),
    .X          (X),
    .flash_mode (flash_mode),
    .hwy        (hwy),
    .cntry      (cntry),
    .state      (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    logic [1:0] hw;
    logic [1:0] cn;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   safety_on = 1'b0;

  task automatic push(input logic [2:0] st, input int n);
    exp_t e;
    e.st = st;
    e.hw = 2'd0;
    e.cn = 2'd0;
    case (st)
      3'd0: begin e.hw = 2'd2; e.cn = 2'd0; end
      3'd1: begin e.hw = 2'd1; e.cn = 2'd0; end
      3'd3: begin e.hw = 2'd0; e.cn = 2'd2; end
      3'd4: begin e.hw = 2'd0; e.cn = 2'd1; end
      default: begin e.hw = 2'd0; e.cn = 2'd0; end
    endcase
    repeat (n) sb_q.push_back(e);
  endtask

  task automatic push_fl(input bit on, input int n);
    exp_t e;
    e.st = 3'd6;
    e.hw = on ? 2'd1 : 2'd3;
    e.cn = on ? 2'd0 : 2'd3;
    repeat (n) sb_q.push_back(e);
  endtask

  // Lamps must never both show a go aspect; a green always faces a red.
  always @(negedge clock) begin
    if (safety_on) begin
      n_checks++;
      if (((hwy == 2'd1 || hwy == 2'd2) && (cntry == 2'd1 || cntry == 2'd2)) ||
          (hwy == 2'd2 && cntry != 2'd0) || (cntry == 2'd2 && hwy != 2'd0)) begin
        $display("FAIL safety t=%0t: hwy=%0d cntry=%0d state=%0d", $time, hwy, cntry, state);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic test_reset();
    exp_t e;
    clear = 1'b1; X = 1'b1; flash_mode = 1'b0;
    push(S_HG, 2);
    for (int c = 0; sb_q.size() != 0; c++) begin
      @(posedge clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st || hwy !== e.hw || cntry !== e.cn)
        $display("FAIL reset obs %0d: got st=%0d hwy=%0d cntry=%0d, want st=%0d hwy=%0d cntry=%0d",
                 c, state, hwy, cntry, e.st, e.hw, e.cn);
      else n_pass++;
    end
    safety_on = 1'b1;
  endtask

  task automatic test_min_green();
    exp_t e;
    push(S_HG, 7); push(S_HY, 3); push(S_AR1, 2); push(S_CG, 1);
    for (int c = 0; sb_q.size() != 0; c++) begin
      if (c == 0) clear = 1'b0;
      @(posedge clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st || hwy !== e.hw || cntry !== e.cn)
        $display("FAIL min_green obs %0d: got st=%0d hwy=%0d cntry=%0d, want st=%0d hwy=%0d cntry=%0d",
                 c, state, hwy, cntry, e.st, e.hw, e.cn);
      else n_pass++;
    end
  endtask

  task automatic test_max_green();
    exp_t e;
    push(S_CG, 15); push(S_CY, 3); push(S_AR2, 2); push(S_HG, 8); push(S_HY, 1);
    for (int c = 0; sb_q.size() != 0; c++) begin
      @(posedge clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st || hwy !== e.hw || cntry !== e.cn)
        $display("FAIL max_green obs %0d: got st=%0d hwy=%0d cntry=%0d, want st=%0d hwy=%0d cntry=%0d",
                 c, state, hwy, cntry, e.st, e.hw, e.cn);
      else n_pass++;
    end
  endtask

  task automatic test_car_leaves();
    exp_t e;
    push(S_HY, 2); push(S_AR1, 2); push(S_CG, 5); push(S_CY, 3); push(S_AR2, 2); push(S_HG, 12);
    for (int c = 0; sb_q.size() != 0; c++) begin
      if (c == 9) X = 1'b0;
      @(posedge clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st || hwy !== e.hw || cntry !== e.cn)
        $display("FAIL car_leaves obs %0d: got st=%0d hwy=%0d cntry=%0d, want st=%0d hwy=%0d cntry=%0d",
                 c, state, hwy, cntry, e.st, e.hw, e.cn);
      else n_pass++;
    end
  endtask

  task automatic test_flash();
    exp_t e;
    push(S_HY, 3); push(S_AR1, 2); push(S_CG, 16); push(S_CY, 3); push(S_AR2, 2); push(S_HG, 1);
    push_fl(1'b1, 4); push_fl(1'b0, 4); push_fl(1'b1, 4);
    push(S_AR2, 2); push(S_HG, 8); push(S_HY, 1);
    for (int c = 0; sb_q.size() != 0; c++) begin
      if (c == 0)  X = 1'b1;
      if (c == 7)  flash_mode = 1'b1;
      if (c == 39) flash_mode = 1'b0;
      @(posedge clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st || hwy !== e.hw || cntry !== e.cn)
        $display("FAIL flash obs %0d: got st=%0d hwy=%0d cntry=%0d, want st=%0d hwy=%0d cntry=%0d",
                 c, state, hwy, cntry, e.st, e.hw, e.cn);
      else n_pass++;
    end
  endtask

  task automatic test_mid_clear();
    exp_t e;
    push(S_HY, 2); push(S_AR1, 1); push(S_HG, 1); push(S_HG, 7); push(S_HY, 1);
    for (int c = 0; sb_q.size() != 0; c++) begin
      if (c == 3) clear = 1'b1;
      if (c == 4) clear = 1'b0;
      @(posedge clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st || hwy !== e.hw || cntry !== e.cn)
        $display("FAIL mid_clear obs %0d: got st=%0d hwy=%0d cntry=%0d, want st=%0d hwy=%0d cntry=%0d",
                 c, state, hwy, cntry, e.st, e.hw, e.cn);
      else n_pass++;
    end
  endtask

  task automatic test_flash_from_hg();
    exp_t e;
    push(S_HG, 1); push_fl(1'b1, 4); push_fl(1'b0, 2); push(S_AR2, 2);
    push(S_HG, 1); push_fl(1'b1, 4); push_fl(1'b0, 1); push(S_AR2, 2); push(S_HG, 3);
    for (int c = 0; sb_q.size() != 0; c++) begin
      if (c == 0) clear = 1'b1;
      if (c == 1) begin clear = 1'b0; flash_mode = 1'b1; end
      if (c == 7) flash_mode = 1'b0;
      if (c == 9) flash_mode = 1'b1;
      if (c == 15) begin flash_mode = 1'b0; X = 1'b0; end
      @(posedge clock); #1;
      e = sb_q.pop_front();
      n_checks++;
      if (state !== e.st || hwy !== e.hw || cntry !== e.cn)
        $display("FAIL flash_from_hg obs %0d: got st=%0d hwy=%0d cntry=%0d, want st=%0d hwy=%0d cntry=%0d",
                 c, state, hwy, cntry, e.st, e.hw, e.cn);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_min_green();
    test_max_green();
    test_car_leaves();
    test_flash();
    test_mid_clear();
    test_flash_from_hg();
    safety_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
